// File: rtl/riscv_crypto_pkg.sv
// Shared definitions for the crypto functional unit and its sequencers:
// FU op-select bit positions, SHA-256 sizes and the schedule FSM states.
package riscv_crypto_pkg;

  localparam int SHA256_SIG0_BIT = 13;
  localparam int SHA256_SIG1_BIT = 12;
  localparam int SHA256_SUM0_BIT = 11;
  localparam int SHA256_SUM1_BIT = 10;

  localparam int FU_INSTR_W   = 20;
  localparam int SHA256_WORDS = 64;
  localparam int SHA256_WIN   = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SIG0 = 2'd1,
    SIG1 = 2'd2
  } sha256_sched_state_e;

  // Build a one-hot FU op-select word from a bit position.
  function automatic logic [FU_INSTR_W-1:0] fu_op_onehot(input int unsigned pos);
    fu_op_onehot = {{(FU_INSTR_W-1){1'b0}}, 1'b1} << pos;
  endfunction

endpackage

// File: rtl/riscv_crypto_sha256_sched_if.sv
// Handshake and FU-operand bundle of the SHA-256 message-schedule sequencer.
// slave is the sequencer's view, master is the parent (block buffer, round
// datapath and crypto FU side).
interface riscv_crypto_sha256_sched_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;

  logic        busy;

  logic [31:0] fu_rs1;
  logic [19:0] fu_instr;
  logic [31:0] fu_rd;

  modport slave (
    input  in_valid, in_word, out_ready, fu_rd,
    output in_ready, out_valid, out_word, out_idx, busy, fu_rs1, fu_instr
  );

  modport master (
    output in_valid, in_word, out_ready, fu_rd,
    input  in_ready, out_valid, out_word, out_idx, busy, fu_rs1, fu_instr
  );

endinterface

// File: rtl/riscv_crypto_sha256_win.sv
// 16-entry sliding window of schedule words: one write port and four
// combinational read ports, cleared by reset.
module riscv_crypto_sha256_win
  import riscv_crypto_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  raddr0_i,
  input  logic [3:0]  raddr1_i,
  input  logic [3:0]  raddr2_i,
  input  logic [3:0]  raddr3_i,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [31:0] rdata3_o
);

  logic [31:0] mem_q [SHA256_WIN];

  // Window storage: single write per cycle, zeroed on reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < SHA256_WIN; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
  assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/riscv_crypto_sha256_sched.sv
// SHA-256 message-schedule sequencer. Streams W[0..15] through from the
// block buffer, then expands W[16..63] two cycles per word by borrowing the
// external crypto FU for sig0 (first cycle) and sig1 (second cycle).
module riscv_crypto_sha256_sched
  import riscv_crypto_pkg::*;
(
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         flush,
  riscv_crypto_sha256_sched_if.slave   bus
);

  localparam logic [FU_INSTR_W-1:0] OP_SIG0     = fu_op_onehot(SHA256_SIG0_BIT);
  localparam logic [FU_INSTR_W-1:0] OP_SIG1     = fu_op_onehot(SHA256_SIG1_BIT);
  localparam logic [5:0]            T_LOAD_LAST = 6'(SHA256_WIN - 1);
  localparam logic [5:0]            T_LAST      = 6'(SHA256_WORDS - 1);

  sha256_sched_state_e state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] s0_q, s0_d;
  logic [31:0] out_word_q, out_word_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;

  logic        slot_free;
  logic        load_acc;
  logic        sig1_go;
  logic        win_we;
  logic [31:0] win_wdata;
  logic [31:0] w_sum;
  logic [31:0] rd_w15, rd_w2, rd_w7, rd_w16;

  // The output slot can take a new word when empty or being drained now.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign load_acc  = (state_q == LOAD) && bus.in_valid && slot_free && !flush;
  assign sig1_go   = (state_q == SIG1) && slot_free;

  // Window slot t&15 holds W[t-16]; offsets 1, 14 and 9 reach W[t-15],
  // W[t-2] and W[t-7]. 4-bit address arithmetic gives the mod-16 wrap.
  riscv_crypto_sha256_win u_win (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .we_i     (win_we),
    .waddr_i  (t_q[3:0]),
    .wdata_i  (win_wdata),
    .raddr0_i (t_q[3:0] + 4'd1),
    .raddr1_i (t_q[3:0] + 4'd14),
    .raddr2_i (t_q[3:0] + 4'd9),
    .raddr3_i (t_q[3:0]),
    .rdata0_o (rd_w15),
    .rdata1_o (rd_w2),
    .rdata2_o (rd_w7),
    .rdata3_o (rd_w16)
  );

  // In SIG1 the FU is returning sig1(W[t-2]); everything else is registered.
  assign w_sum     = bus.fu_rd + rd_w7 + s0_q + rd_w16;
  assign win_we    = !flush && (load_acc || sig1_go);
  assign win_wdata = (state_q == LOAD) ? bus.in_word : w_sum;

  // FU operand and op select decoded from the current state.
  always_comb begin
    bus.fu_instr = '0;
    bus.fu_rs1   = '0;
    case (state_q)
      SIG0: begin
        bus.fu_instr = OP_SIG0;
        bus.fu_rs1   = rd_w15;
      end
      SIG1: begin
        bus.fu_instr = OP_SIG1;
        bus.fu_rs1   = rd_w2;
      end
      default: ;
    endcase
  end

  // Next-state logic: flush overrides every transition and any load.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    s0_d        = s0_q;
    out_word_d  = out_word_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (flush) begin
      state_d     = LOAD;
      t_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_acc) begin
            out_word_d  = bus.in_word;
            out_idx_d   = t_q;
            out_valid_d = 1'b1;
            t_d         = t_q + 6'd1;
            if (t_q == T_LOAD_LAST) state_d = SIG0;
          end
        end
        SIG0: begin
          s0_d    = bus.fu_rd;
          state_d = SIG1;
        end
        SIG1: begin
          if (slot_free) begin
            out_word_d  = w_sum;
            out_idx_d   = t_q;
            out_valid_d = 1'b1;
            if (t_q == T_LAST) begin
              t_d     = '0;
              state_d = LOAD;
            end else begin
              t_d     = t_q + 6'd1;
              state_d = SIG0;
            end
          end
        end
        default: begin
          state_d = LOAD;
          t_d     = '0;
        end
      endcase
    end
  end

  // FSM, index counter, sig0 capture and output register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= LOAD;
      t_q         <= '0;
      s0_q        <= '0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      s0_q        <= s0_d;
      out_word_q  <= out_word_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD) && slot_free && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = (state_q != LOAD) || (t_q != '0) || out_valid_q;

endmodule

// File: tb/tb_riscv_crypto_sha256_sched.sv
// Bench for the SHA-256 schedule sequencer: a behavioural sig0/sig1 FU sits
// beside the DUT, and expected schedules come from the textbook recurrence.
module tb_riscv_crypto_sha256_sched;

  localparam logic [19:0] OP_SIG0 = 20'h02000;
  localparam logic [19:0] OP_SIG1 = 20'h01000;

  logic g_clk = 1'b0;
  logic g_resetn;
  logic flush;

  riscv_crypto_sha256_sched_if bus ();

  riscv_crypto_sha256_sched dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (flush),
    .bus      (bus)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Crypto FU stand-in: combinational, zero when no op is selected.
  always_comb begin
    bus.fu_rd = 32'h0;
    if (bus.fu_instr == OP_SIG0)      bus.fu_rd = ssig0(bus.fu_rs1);
    else if (bus.fu_instr == OP_SIG1) bus.fu_rd = ssig1(bus.fu_rs1);
  end

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] src[$];
  logic [5:0]  got_idx[$];
  logic [31:0] got_word[$];
  logic [31:0] exp_w [128];
  int          ptr, cyc_n, first_acc_cyc, w63_cyc, acc16_cyc, stall_nr;
  bit          rnd_v, rnd_r, chk_stable, prev_stall;
  logic [31:0] prev_word;
  logic [5:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests_run++;
    assert (obs === want) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drive();
    bus.in_valid  = (ptr < src.size()) && (!rnd_v || ($urandom_range(0, 1) == 1));
    bus.in_word   = (ptr < src.size()) ? src[ptr] : $urandom;
    bus.out_ready = !rnd_r || ($urandom_range(0, 1) == 1);
  endtask

  // One clock: drive after the edge, observe at the falling edge.
  task automatic cyc();
    bit legal;
    drive();
    @(negedge g_clk);
    legal = (bus.fu_instr == 20'h0) || (bus.fu_instr == OP_SIG0) || (bus.fu_instr == OP_SIG1);
    if (bus.in_ready) legal = legal && (bus.fu_instr == 20'h0) && (bus.fu_rs1 == 32'h0);
    check("fu_op_legal", 32'(legal), 32'd1);
    if (bus.in_valid && bus.in_ready) begin
      if (ptr == 0)  first_acc_cyc = cyc_n;
      if (ptr == 16) acc16_cyc = cyc_n;
      ptr++;
    end
    if (bus.in_valid && !bus.in_ready) stall_nr++;
    if (bus.out_valid && bus.out_idx == 6'd63 && w63_cyc < 0) w63_cyc = cyc_n;
    if (chk_stable && prev_stall) begin
      check("hold_word", bus.out_word, prev_word);
      check("hold_idx", 32'(bus.out_idx), 32'(prev_idx));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_word  = bus.out_word;
    prev_idx   = bus.out_idx;
    if (bus.out_valid && bus.out_ready) begin
      got_idx.push_back(bus.out_idx);
      got_word.push_back(bus.out_word);
    end
    @(posedge g_clk);
    #1;
    cyc_n++;
  endtask

  task automatic new_test(input bit rv, input bit rr);
    src.delete();
    got_idx.delete();
    got_word.delete();
    ptr = 0; first_acc_cyc = -1; w63_cyc = -1; acc16_cyc = -1; stall_nr = 0;
    prev_stall = 1'b0; chk_stable = 1'b0; rnd_v = rv; rnd_r = rr;
  endtask

  task automatic load_abc();
    src.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) src.push_back(32'h0);
    src.push_back(32'h00000018);
  endtask

  task automatic run_until(input int nout, input int budget);
    int n;
    n = 0;
    while (got_word.size() < nout && n < budget) begin
      cyc();
      n++;
    end
    check("words_collected", got_word.size(), nout);
    rnd_v = 1'b0;
    rnd_r = 1'b0;
  endtask

  task automatic build_model(input int nblk);
    for (int b = 0; b < nblk; b++)
      for (int t = 0; t < 64; t++)
        if (t < 16) exp_w[b*64+t] = src[b*16+t];
        else exp_w[b*64+t] = ssig1(exp_w[b*64+t-2]) + exp_w[b*64+t-7]
                             + ssig0(exp_w[b*64+t-15]) + exp_w[b*64+t-16];
  endtask

  task automatic check_block(input int nblk);
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < 64; i++) begin
        check("sched_idx", 32'(got_idx[b*64+i]), i);
        check("sched_word", got_word[b*64+i], exp_w[b*64+i]);
      end
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    int n;
    n = 0;
    while (!(got_idx.size() > 0 && got_idx[$] == idx) && n < 300) begin
      cyc();
      n++;
    end
    check("reach_idx", 32'(got_idx.size()), 32'(idx) + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g_resetn = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = 32'h0;
    bus.out_ready = 1'b1;
    cyc_n = 0;
    new_test(1'b0, 1'b0);
    #22 g_resetn = 1'b1;
    @(posedge g_clk);
    #1;

    // Reset values
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_word", bus.out_word, 32'h0);
    check("rst_fu_instr", 32'(bus.fu_instr), 32'd0);
    check("rst_fu_rs1", bus.fu_rs1, 32'h0);

    // abc block, no backpressure
    new_test(1'b0, 1'b0);
    load_abc();
    run_until(64, 400);
    build_model(1);
    check("abc_W16", got_word[16], 32'h61626380);
    check("abc_W17", got_word[17], 32'h000F0000);
    check_block(1);
    check("abc_w63_latency", w63_cyc - first_acc_cyc, 112);
    repeat (2) cyc();
    check("abc_idle_busy", 32'(bus.busy), 32'd0);

    // random words, random in_valid gaps and out_ready
    new_test(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) src.push_back($urandom);
    chk_stable = 1'b1;
    run_until(64, 3000);
    chk_stable = 1'b0;
    build_model(1);
    check_block(1);
    repeat (3) cyc();

    // two back-to-back blocks, in_valid held high
    new_test(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) src.push_back($urandom);
    run_until(128, 800);
    build_model(2);
    check_block(2);
    check("b2b_second_w0_cycle", acc16_cyc, w63_cyc);
    check("b2b_in_ready_low_cycles", stall_nr, 96);
    repeat (2) cyc();

    // flush while in SIG1 at t=30
    new_test(1'b0, 1'b0);
    load_abc();
    wait_idx(6'd29);
    check("pre_flush_sig1", 32'(bus.fu_instr), 32'(OP_SIG1));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    new_test(1'b0, 1'b0);
    load_abc();
    run_until(18, 100);
    check("post_flush_W16", got_word[16], 32'h61626380);
    check("post_flush_idx16", 32'(got_idx[16]), 32'd16);
    check("post_flush_W17", got_word[17], 32'h000F0000);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // asynchronous reset mid-block at t=40
    new_test(1'b0, 1'b0);
    load_abc();
    wait_idx(6'd39);
    #2 g_resetn = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_fu_instr", 32'(bus.fu_instr), 32'd0);
    check("arst_fu_rs1", bus.fu_rs1, 32'h0);
    check("arst_out_idx", 32'(bus.out_idx), 32'd0);
    check("arst_out_word", bus.out_word, 32'h0);
    @(posedge g_clk);
    #3 g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    new_test(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("arst_no_spurious_valid", 32'(bus.out_valid), 32'd0);
    end
    new_test(1'b0, 1'b0);
    load_abc();
    run_until(64, 400);
    build_model(1);
    check_block(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
